// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for conv_window_gen; master = stream source and window sink, slave = generator.
// CONV_WIN_COORD_EN adds the o_win_row / o_win_col window-coordinate signals.
interface conv_window_gen_if #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 8
);
    localparam int RW = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;
    localparam int CW = (IMG_W > 3) ? $clog2(IMG_W - 2) : 1;

    logic              i_start;
    logic              i_pix_valid;
    logic              o_pix_ready;
    logic [DW-1:0]     i_pix;
    logic              o_win_valid;
    logic              i_win_ready;
    logic [9*DW-1:0]   o_win;
    logic              o_busy;
    logic              o_frame_done;
`ifdef CONV_WIN_COORD_EN
    logic [RW-1:0]     o_win_row;
    logic [CW-1:0]     o_win_col;

    modport master (
        output i_start, i_pix_valid, i_pix, i_win_ready,
        input  o_pix_ready, o_win_valid, o_win, o_busy, o_frame_done, o_win_row, o_win_col
    );
    modport slave (
        input  i_start, i_pix_valid, i_pix, i_win_ready,
        output o_pix_ready, o_win_valid, o_win, o_busy, o_frame_done, o_win_row, o_win_col
    );
`else
    modport master (
        output i_start, i_pix_valid, i_pix, i_win_ready,
        input  o_pix_ready, o_win_valid, o_win, o_busy, o_frame_done
    );
    modport slave (
        input  i_start, i_pix_valid, i_pix, i_win_ready,
        output o_pix_ready, o_win_valid, o_win, o_busy, o_frame_done
    );
`endif
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift window, no padding.
// CONV_WIN_COORD_EN registers the window's top-left coordinate alongside o_win.
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    conv_window_gen_if.slave   bus
);
    localparam int TOTAL  = IMG_W * IMG_H;
    localparam int PW     = $clog2(TOTAL + 1);
    localparam int CNT_CW = $clog2(IMG_W);
    localparam int CNT_RW = $clog2(IMG_H + 1);
`ifdef CONV_WIN_COORD_EN
    localparam int RW = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;
    localparam int CW = (IMG_W > 3) ? $clog2(IMG_W - 2) : 1;
`endif

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       pixels_in;
    logic [CNT_CW-1:0]   col;
    logic [CNT_RW-1:0]   row;
    logic [DW-1:0]       lb_top [IMG_W];
    logic [DW-1:0]       lb_mid [IMG_W];
    logic [DW-1:0]       win_q  [3][3];
    logic [DW-1:0]       win_d  [3][3];
    logic [9*DW-1:0]     win_flat;
    logic [9*DW-1:0]     win_data;
    logic                win_valid;
    logic                pix_ready;
    logic                pix_fire;
    logic                win_fire;
    logic                emit;
`ifdef CONV_WIN_COORD_EN
    logic [RW-1:0]       win_row;
    logic [CW-1:0]       win_col;
`endif

    always_comb begin
        pix_ready = (state == FILL || state == RUN) && (pixels_in < PW'(TOTAL))
                    && (!win_valid || bus.i_win_ready);
        pix_fire  = bus.i_pix_valid && pix_ready;
        win_fire  = win_valid && bus.i_win_ready;
        emit      = pix_fire && (row >= CNT_RW'(2)) && (col >= CNT_CW'(2));
    end

    // Window shifts left one column per accepted pixel; the new right column is
    // (row r-2, row r-1, current pixel) read from the line buffers at this column.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
        end
        win_d[0][2] = lb_top[col];
        win_d[1][2] = lb_mid[col];
        win_d[2][2] = bus.i_pix;
        win_flat = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                win_flat[DW*(3*i+j) +: DW] = win_d[i][j];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (pix_fire) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= bus.i_pix;
            win_q       <= win_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            pixels_in <= '0;
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_data  <= '0;
`ifdef CONV_WIN_COORD_EN
            win_row   <= '0;
            win_col   <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.i_start) begin
                pixels_in <= '0;
                col       <= '0;
                row       <= '0;
            end else if (pix_fire) begin
                pixels_in <= pixels_in + PW'(1);
                if (col == CNT_CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + CNT_RW'(1);
                end else begin
                    col <= col + CNT_CW'(1);
                end
            end
            // A new window replaces the current one in the same edge it is handshaken.
            if (emit) begin
                win_valid <= 1'b1;
                win_data  <= win_flat;
`ifdef CONV_WIN_COORD_EN
                win_row   <= RW'(row - CNT_RW'(2));
                win_col   <= CW'(col - CNT_CW'(2));
`endif
            end else if (win_fire) begin
                win_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        bus.o_pix_ready  = pix_ready;
        bus.o_busy       = 1'b0;
        bus.o_frame_done = 1'b0;
        case (state)
            IDLE: if (bus.i_start) state_nxt = FILL;
            FILL: begin
                bus.o_busy = 1'b1;
                if (pix_fire && row == CNT_RW'(2) && col == '0) state_nxt = RUN;
            end
            RUN: begin
                bus.o_busy = 1'b1;
                if (pixels_in == PW'(TOTAL) && win_fire) state_nxt = DONE;
            end
            DONE: begin
                bus.o_frame_done = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.o_win_valid = win_valid;
    assign bus.o_win       = win_data;
`ifdef CONV_WIN_COORD_EN
    assign bus.o_win_row   = win_row;
    assign bus.o_win_col   = win_col;
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed self-checking bench for conv_window_gen (ramp, content, backpressure, bubbles, reset, restart).
// Coordinate outputs are also checked when CONV_WIN_COORD_EN is defined.
module tb_conv_window_gen;
    localparam int W     = 28;
    localparam int H     = 28;
    localparam int DW    = 8;
    localparam int NWIN  = (W - 2) * (H - 2);
    localparam int TOTAL = W * H;

    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    conv_window_gen_if #(.IMG_W(W), .IMG_H(H), .DW(DW)) bus ();

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int pat, input int r, input int c);
        case (pat)
            0:       return 8'(c);
            1:       return 8'((r * 28 + c) % 256);
            default: return 8'((r * 37 + c * 11 + (r ^ c)) % 256);
        endcase
    endfunction

    function automatic logic [71:0] win_val(input int pat, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = pix_val(pat, r + i, c + j);
        return w;
    endfunction

    task automatic run_frame(input int pat, input bit bubbles, input bit bp,
                             input bit restart_pulse, input int abort_at);
        int          sent = 0;
        int          got = 0;
        int          dones = 0;
        int          cyc = 0;
        int          fire58 = -1;
        int          bp_cnt = 0;
        bit          first_seen = 1'b0;
        bit          pulsed = 1'b0;
        bit          holding;
        bit          prev_busy = 1'b1;
        bit          pfire;
        bit          wfire;
        logic [71:0] held = '0;

        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_pix_valid = 1'b0;
        bus.i_win_ready = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("busy_after_start", bus.o_busy, 1);

        while (cyc < 20000) begin
            if (bus.o_frame_done) begin
                dones++;
                break;
            end
            prev_busy = bus.o_busy;
            if (bus.o_win_valid && !first_seen) begin
                first_seen = 1'b1;
                check("first_win_latency", cyc, fire58 + 1);
            end

            holding = bp && bus.o_win_valid && got == 3 * (W - 2) + 7 && bp_cnt < 5;
            if (holding) begin
                if (bp_cnt == 0) held = bus.o_win;
                else begin
                    check("bp_win_stable", bus.o_win, held);
                    check("bp_valid_stable", bus.o_win_valid, 1);
                end
                bp_cnt++;
                bus.i_win_ready = 1'b0;
            end else if (bubbles) begin
                bus.i_win_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.i_win_ready = 1'b1;
            end

            if (sent < TOTAL && (!bubbles || $urandom_range(0, 99) >= 30)) begin
                bus.i_pix_valid = 1'b1;
                bus.i_pix       = pix_val(pat, sent / W, sent % W);
            end else begin
                bus.i_pix_valid = 1'b0;
                bus.i_pix       = '0;
            end

            if (restart_pulse && sent == 300 && !pulsed) begin
                bus.i_start = 1'b1;
                pulsed      = 1'b1;
            end else begin
                bus.i_start = 1'b0;
            end

            #1;
            if (holding) check("bp_pix_ready", bus.o_pix_ready, 0);
            pfire = bus.i_pix_valid && bus.o_pix_ready;
            wfire = bus.o_win_valid && bus.i_win_ready;
            if (wfire) begin
                check("win", bus.o_win, win_val(pat, got / (W - 2), got % (W - 2)));
`ifdef CONV_WIN_COORD_EN
                check("win_row", bus.o_win_row, got / (W - 2));
                check("win_col", bus.o_win_col, got % (W - 2));
`endif
                if (pat == 0 && got == 0) check("ramp_first_win", bus.o_win, 72'h020100020100020100);
                if (pat == 1 && got == NWIN - 1) check("content_last_win", bus.o_win, 72'h0f0e0df3f2f1d7d6d5);
                got++;
            end
            if (pfire) begin
                if (sent == 2 * W + 2) fire58 = cyc;
                sent++;
            end
            @(negedge clk);
            cyc++;
            if (abort_at > 0 && sent >= abort_at) break;
        end
        bus.i_start = 1'b0;

        if (abort_at > 0) begin
            check("abort_pixels", sent, abort_at);
            rstn = 1'b0;
            #1;
            check("rst_pix_ready", bus.o_pix_ready, 0);
            check("rst_win_valid", bus.o_win_valid, 0);
            check("rst_win", bus.o_win, 0);
            check("rst_busy", bus.o_busy, 0);
            check("rst_frame_done", bus.o_frame_done, 0);
            @(negedge clk);
            rstn = 1'b1;
            @(negedge clk);
            check("post_rst_busy", bus.o_busy, 0);
            check("post_rst_win_valid", bus.o_win_valid, 0);
            return;
        end

        bus.i_pix_valid = 1'b0;
        check("done_seen", dones, 1);
        check("win_count", got, NWIN);
        check("pix_count", sent, TOTAL);
        check("busy_at_done", bus.o_busy, 0);
        check("busy_before_done", prev_busy, 1);
        check("win_valid_at_done", bus.o_win_valid, 0);
        if (bp) check("bp_applied", bp_cnt, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("done_single_pulse", bus.o_frame_done, 0);
            check("idle_busy", bus.o_busy, 0);
        end
    endtask

    initial begin
        rstn            = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_pix_valid = 1'b0;
        bus.i_pix       = '0;
        bus.i_win_ready = 1'b0;
        #23;
        check("reset_pix_ready", bus.o_pix_ready, 0);
        check("reset_win_valid", bus.o_win_valid, 0);
        check("reset_win", bus.o_win, 0);
        check("reset_busy", bus.o_busy, 0);
        check("reset_frame_done", bus.o_frame_done, 0);
`ifdef CONV_WIN_COORD_EN
        check("reset_win_row", bus.o_win_row, 0);
        check("reset_win_col", bus.o_win_col, 0);
`endif
        rstn = 1'b1;

        run_frame(0, 1'b0, 1'b0, 1'b0, 0);
        run_frame(1, 1'b0, 1'b0, 1'b0, 0);
        run_frame(1, 1'b0, 1'b1, 1'b0, 0);
        run_frame(2, 1'b1, 1'b0, 1'b0, 0);
        run_frame(2, 1'b0, 1'b0, 1'b0, 100);
        run_frame(2, 1'b1, 1'b0, 1'b0, 0);
        run_frame(0, 1'b0, 1'b0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
